instr_mem_loader: RTL and testbench
===================================

// Module: instr_mem_loader
// PURPOSE
//  Instruction memory for the single-cycle RISC-V core, with a byte-stream program loader.
//  After reset it accepts a length-prefixed program over a valid/ready byte interface and
//  writes it word by word into an internal RAM.
//  It holds the core in reset until loading completes, then serves Instr combinationally
//  from the core's PC.
// PARAMETERS
//  ADDR_W    6              word-address width; RAM depth MEM_WORDS = 2**ADDR_W
//  NOP_INSTR 32'h00000013   value driven on Instr when no valid word is addressed (addi x0,x0,0)
// PORTS
//  clk        in   1         single clock; all state updates on the rising edge
//  reset      in   1         synchronous, active-high reset
//  rx_valid   in   1         loader byte valid
//  rx_data    in   8         loader byte
//  rx_ready   out  1         loader can accept a byte this cycle
//  PC         in   32        fetch address from the core (byte address)
//  Instr      out  32        instruction to the core (combinational read)
//  cpu_reset  out  1         registered; hold-in-reset to the core, 1 until the program is loaded
//  load_done  out  1         registered; 1 in RUN
//  load_err   out  1         registered; 1 in ERR
//  word_count out  ADDR_W+1  number of program words accepted (the header value once RUN)
// BEHAVIOUR
//  - Reset (sync, active-high):
//      state=LEN0, byte_idx=0, wr_addr=0, word_count=0
//      cpu_reset=1, load_done=0, load_err=0
//      RAM contents are not cleared; reads are gated instead (see Instr).
//  - Transfer rule: a byte transfers on a rising edge with rx_valid && rx_ready.
//      rx_ready=1 only in LEN0/LEN1/DATA.
//      Bytes offered in RUN/ERR are ignored, and no state changes.
//      rx_data may change freely while rx_valid=0.
//  - Stream format: N[7:0], N[15:8], then 4*N bytes, each word little-endian (b0 first).
//  - FSM:
//      LEN0 --xfer--> LEN1; latch N[7:0].
//      LEN1 --xfer--> DATA if 1 <= N <= MEM_WORDS; otherwise --> ERR.
//      DATA: collect bytes b0..b3 (byte_idx 0..3).
//        On the b3 transfer, write {b3,b2,b1,b0} to RAM[wr_addr]; wr_addr++, word_count++.
//        If that word is word N, go to RUN on the same edge.
//      RUN: terminal until reset; cpu_reset=0, load_done=1.
//      ERR: terminal until reset; cpu_reset=1, load_err=1, Instr=NOP_INSTR.
//  - Latency: cpu_reset falls, and load_done rises, on the same edge that accepts the final byte.
//    The written word is readable on Instr from the following cycle.
//  - Instr (combinational):
//      RAM[PC[ADDR_W+1:2]] when all of these hold:
//        state==RUN, PC[1:0]==0, PC[31:ADDR_W+2]==0, PC[ADDR_W+1:2] < word_count.
//      Otherwise NOP_INSTR (misaligned, out-of-range, unloaded, or not RUN).
//  - Width rules:
//      word_count saturates by construction at MEM_WORDS (N is checked in LEN1).
//      wr_addr never wraps.
//      The N comparison uses the full 16 bits, so N=MEM_WORDS is legal and N=MEM_WORDS+1 is ERR.
//  - Reset mid-load: the partial word and count are discarded; the next byte is treated as N[7:0].
//  - Simultaneous reset and transfer: reset wins; the byte is dropped.
// TESTING
//  1. Load N=2, words 32'h00500093, 32'h00100113 (bytes 02 00 93 00 50 00 13 01 10 00), rx_valid held high:
//     -> cpu_reset falls on the 10th accept edge; word_count=2.
//     -> PC=0 gives Instr=00500093; PC=4 gives 00100113; PC=8 gives 00000013.
//  2. Same stream with rx_valid toggling every other cycle: identical RAM and timing in accepted-byte count.
//     rx_ready=0 after RUN.
//  3. N=0 -> ERR after 2nd byte: load_err=1, cpu_reset=1, rx_ready=0; further bytes ignored; Instr=00000013.
//  4. N=65 with ADDR_W=6 -> ERR.
//     N=64 with 256 data bytes -> RUN; PC=252 returns word 63; PC=256 returns NOP.
//  5. After RUN: PC=2 (misaligned) -> NOP.
//     PC=32'h1000_0000 -> NOP.
//  6. Assert reset after 5 data bytes of an N=2 load, then send a fresh N=1 stream:
//     -> word_count=1; only the new word is visible; cpu_reset falls on the 6th accept edge.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - instruction RAM with a length-prefixed byte-stream program loader
// Holds the core in reset until N little-endian words are written, then serves Instr from PC.
module instr_mem_loader #(
    parameter int          ADDR_W    = 6,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [31:0]       PC,
    output logic [31:0]       Instr,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);
    localparam int MEM_WORDS = 2 ** ADDR_W;

    typedef enum logic [2:0] {S_LEN0, S_LEN1, S_DATA, S_RUN, S_ERR} state_t;

    state_t              state_q, state_d;
    logic [7:0]          len_lo_q, len_lo_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         bytes_q, bytes_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;

    logic [31:0]         mem [MEM_WORDS];

    logic                xfer;
    logic [15:0]         n_full;
    logic                n_ok;
    logic                word_done;
    logic                last_word;
    logic [ADDR_W-1:0]   rd_idx;
    logic                rd_hit;

    assign xfer      = rx_valid && rx_ready;
    assign n_full    = {rx_data, len_lo_q};
    // Full 16-bit compare so N = MEM_WORDS+1 cannot alias into range.
    assign n_ok      = (n_full != 16'd0) && (n_full <= 16'(MEM_WORDS));
    assign word_done = xfer && (state_q == S_DATA) && (byte_idx_q == 2'd3);
    assign last_word = ((word_count_q + (ADDR_W+1)'(1)) == n_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_LEN0;
            len_lo_q     <= 8'd0;
            n_q          <= '0;
            byte_idx_q   <= 2'd0;
            bytes_q      <= 24'd0;
            wr_addr_q    <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            n_q          <= n_d;
            byte_idx_q   <= byte_idx_d;
            bytes_q      <= bytes_d;
            wr_addr_q    <= wr_addr_d;
            word_count_q <= word_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN0:  if (xfer) state_d = S_LEN1;
            S_LEN1:  if (xfer) state_d = n_ok ? S_DATA : S_ERR;
            S_DATA:  if (word_done && last_word) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase
    end

    always_comb begin
        len_lo_d     = len_lo_q;
        n_d          = n_q;
        byte_idx_d   = byte_idx_q;
        bytes_d      = bytes_q;
        wr_addr_d    = wr_addr_q;
        word_count_d = word_count_q;
        if (xfer) begin
            case (state_q)
                S_LEN0: len_lo_d = rx_data;
                S_LEN1: if (n_ok) n_d = n_full[ADDR_W:0];
                S_DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    bytes_d    = {rx_data, bytes_q[23:8]};
                    if (word_done) begin
                        word_count_d = word_count_q + (ADDR_W+1)'(1);
                        // Stop advancing on the final word so wr_addr never wraps.
                        if (!last_word) wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_ready  = 1'b0;
        cpu_reset = 1'b1;
        load_done = 1'b0;
        load_err  = 1'b0;
        case (state_q)
            S_LEN0, S_LEN1, S_DATA: rx_ready = 1'b1;
            S_RUN: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
            end
            S_ERR:   load_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && word_done) mem[wr_addr_q] <= {rx_data, bytes_q};
    end

    assign word_count = word_count_q;
    assign rd_idx     = PC[ADDR_W+1:2];
    assign rd_hit     = (state_q == S_RUN) && (PC[1:0] == 2'b00) &&
                        (PC[31:ADDR_W+2] == '0) && ({1'b0, rd_idx} < word_count_q);
    assign Instr      = rd_hit ? mem[rd_idx] : NOP_INSTR;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - scoreboard bench for instr_mem_loader
module tb_instr_mem_loader;
    localparam int ADDR_W = 6;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int SEL_INSTR = 0, SEL_CPURST = 1, SEL_DONE = 2, SEL_ERR = 3,
                   SEL_READY = 4, SEL_WCNT = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic [31:0]       PC;
    logic [31:0]       Instr;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;

    instr_mem_loader #(.ADDR_W(ADDR_W), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .PC(PC), .Instr(Instr), .cpu_reset(cpu_reset),
        .load_done(load_done), .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   fall_q[$];
    logic probe = 1'b0;
    int   acc = 0;
    int   passed = 0;
    int   total = 0;
    logic prev_cr = 1'b1;

    always @(posedge clk) begin
        if (reset) acc <= 0;
        else if (rx_valid && rx_ready) acc <= acc + 1;
    end

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (probe && sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_INSTR:  act = Instr;
                SEL_CPURST: act = 32'(cpu_reset);
                SEL_DONE:   act = 32'(load_done);
                SEL_ERR:    act = 32'(load_err);
                SEL_READY:  act = 32'(rx_ready);
                default:    act = 32'(word_count);
            endcase
            total++;
            if (act === e.exp) passed++;
            else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
        if (prev_cr === 1'b1 && cpu_reset === 1'b0) begin
            total++;
            if (fall_q.size() == 0) begin
                $display("FAIL cpu_reset_fall: got unexpected fall at accept %0d expected none", acc);
            end else begin
                int n;
                n = fall_q.pop_front();
                if (acc == n) passed++;
                else $display("FAIL cpu_reset_fall: got accept %0d expected accept %0d", acc, n);
            end
        end
        prev_cr = cpu_reset;
    end

    task automatic check(input string name, input int sel, input logic [31:0] exp);
        sb.push_back('{name, sel, exp});
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic check_pc(input string name, input logic [31:0] pc, input logic [31:0] exp);
        PC = pc;
        check(name, SEL_INSTR, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit toggle);
        bit ok;
        if (toggle) begin
            rx_valid = 1'b0;
            rx_data  = 8'hEE;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!ok) begin
            total++;
            $display("FAIL send_byte: got no accept for %h expected accept", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit toggle);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], toggle);
    endtask

    task automatic offer_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic two_word_load(input bit toggle, input string tag);
        fall_q.push_back(10);
        send_byte(8'h02, toggle);
        send_byte(8'h00, toggle);
        send_word(32'h0050_0093, toggle);
        send_word(32'h0010_0113, toggle);
        check({tag, "_wcnt"}, SEL_WCNT, 32'd2);
        check({tag, "_done"}, SEL_DONE, 32'd1);
        check({tag, "_cpurst"}, SEL_CPURST, 32'd0);
        check({tag, "_ready"}, SEL_READY, 32'd0);
        check_pc({tag, "_pc0"}, 32'd0, 32'h0050_0093);
        check_pc({tag, "_pc4"}, 32'd4, 32'h0010_0113);
        check_pc({tag, "_pc8"}, 32'd8, NOP);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        PC       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_cpurst", SEL_CPURST, 32'd1);
        check("rst_done", SEL_DONE, 32'd0);
        check("rst_err", SEL_ERR, 32'd0);
        check("rst_wcnt", SEL_WCNT, 32'd0);
        check("rst_ready", SEL_READY, 32'd1);
        check_pc("rst_instr", 32'd0, NOP);

        two_word_load(1'b0, "t1");
        check_pc("t5_misalign", 32'd2, NOP);
        check_pc("t5_high", 32'h1000_0000, NOP);

        do_reset();
        two_word_load(1'b1, "t2");

        do_reset();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        offer_byte(8'h01);
        offer_byte(8'h00);
        check("t3_err", SEL_ERR, 32'd1);
        check("t3_cpurst", SEL_CPURST, 32'd1);
        check("t3_ready", SEL_READY, 32'd0);
        check("t3_done", SEL_DONE, 32'd0);
        check("t3_wcnt", SEL_WCNT, 32'd0);
        check_pc("t3_instr", 32'd0, NOP);

        do_reset();
        send_byte(8'h41, 1'b0);
        send_byte(8'h00, 1'b0);
        check("t4_n65_err", SEL_ERR, 32'd1);

        do_reset();
        fall_q.push_back(258);
        send_byte(8'h40, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 64; i++) send_word(32'hDEAD_0000 | 32'(i), 1'b0);
        check("t4_wcnt", SEL_WCNT, 32'd64);
        check("t4_done", SEL_DONE, 32'd1);
        check_pc("t4_pc252", 32'd252, 32'hDEAD_003F);
        check_pc("t4_pc0", 32'd0, 32'hDEAD_0000);
        check_pc("t4_pc256", 32'd256, NOP);

        do_reset();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'hCAFE_BABE, 1'b0);
        send_byte(8'h77, 1'b0);
        // Reset coincides with an offered byte; that byte must be dropped.
        rx_valid = 1'b1;
        rx_data  = 8'h05;
        do_reset();
        rx_valid = 1'b0;
        fall_q.push_back(6);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        check("t6_wcnt", SEL_WCNT, 32'd1);
        check("t6_done", SEL_DONE, 32'd1);
        check_pc("t6_pc0", 32'd0, 32'h1234_5678);
        check_pc("t6_pc4", 32'd4, NOP);

        repeat (2) @(posedge clk);
        if (fall_q.size() != 0) begin
            total += fall_q.size();
            $display("FAIL cpu_reset_fall: got %0d missing falls expected 0", fall_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
